// File: rtl/uart_rx.sv
// Oversampling UART receiver: start + 8 data bits (LSB first) + optional parity + stop.
// Define UART_RX_ERR_FLAGS_EN to expose the UartRx_Par_Err / UartRx_Stp_Err status outputs.
module uart_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 5
) (
    input  logic                      UartRx_CLK,
    input  logic                      UartRx_RST,
    input  logic [PRESCALE_WIDTH-1:0] UartRx_prescale,
    input  logic                      UartRx_RX_IN,
    input  logic                      UartRx_PAR_EN,
    input  logic                      UartRx_Par_Type,
    output logic [DATA_WIDTH-1:0]     UartRx_PDATA,
    output logic                      UartRx_Data_Valid
`ifdef UART_RX_ERR_FLAGS_EN
    ,
    output logic                      UartRx_Par_Err,
    output logic                      UartRx_Stp_Err
`endif
);

    localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rxState_t;

    rxState_t                  stateReg,     stateNext;
    logic [PRESCALE_WIDTH-1:0] edgeCntReg,   edgeCntNext;
    logic [BIT_CNT_WIDTH-1:0]  bitCntReg,    bitCntNext;
    logic                      sampleAReg,   sampleANext;
    logic                      sampleBReg,   sampleBNext;
    logic [DATA_WIDTH-1:0]     holdReg,      holdNext;
    logic                      parErrReg,    parErrNext;
    logic [PRESCALE_WIDTH-1:0] prescaleReg,  prescaleNext;
    logic                      parEnReg,     parEnNext;
    logic                      parTypeReg,   parTypeNext;
    logic [DATA_WIDTH-1:0]     pdataReg,     pdataNext;
    logic                      dataValidReg, dataValidNext;
`ifdef UART_RX_ERR_FLAGS_EN
    logic                      stpErrReg,    stpErrNext;
`endif

    logic [PRESCALE_WIDTH-1:0] halfCnt;
    logic                      atEarly;
    logic                      atMid;
    logic                      atDecide;
    logic                      atEnd;
    logic                      voted;
    logic                      expectedPar;

    // Sample points sit around the bit centre: P/2-1, P/2, P/2+1 with P = prescale+1.
    assign halfCnt     = (prescaleReg >> 1) + PRESCALE_WIDTH'(1);
    assign atEarly     = (edgeCntReg == (halfCnt - PRESCALE_WIDTH'(1)));
    assign atMid       = (edgeCntReg == halfCnt);
    assign atDecide    = (edgeCntReg == (halfCnt + PRESCALE_WIDTH'(1)));
    assign atEnd       = (edgeCntReg == prescaleReg);
    // Third sample is taken live on the decision clock.
    assign voted       = (sampleAReg & sampleBReg) | (sampleAReg & UartRx_RX_IN) | (sampleBReg & UartRx_RX_IN);
    assign expectedPar = (^holdReg) ^ parTypeReg;

    always_ff @(posedge UartRx_CLK or posedge UartRx_RST) begin
        if (UartRx_RST) begin
            stateReg     <= IDLE;
            edgeCntReg   <= '0;
            bitCntReg    <= '0;
            sampleAReg   <= 1'b1;
            sampleBReg   <= 1'b1;
            holdReg      <= '0;
            parErrReg    <= 1'b0;
            prescaleReg  <= '0;
            parEnReg     <= 1'b0;
            parTypeReg   <= 1'b0;
            pdataReg     <= '0;
            dataValidReg <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
            stpErrReg    <= 1'b0;
`endif
        end else begin
            stateReg     <= stateNext;
            edgeCntReg   <= edgeCntNext;
            bitCntReg    <= bitCntNext;
            sampleAReg   <= sampleANext;
            sampleBReg   <= sampleBNext;
            holdReg      <= holdNext;
            parErrReg    <= parErrNext;
            prescaleReg  <= prescaleNext;
            parEnReg     <= parEnNext;
            parTypeReg   <= parTypeNext;
            pdataReg     <= pdataNext;
            dataValidReg <= dataValidNext;
`ifdef UART_RX_ERR_FLAGS_EN
            stpErrReg    <= stpErrNext;
`endif
        end
    end

    always_comb begin
        stateNext     = stateReg;
        edgeCntNext   = edgeCntReg;
        bitCntNext    = bitCntReg;
        sampleANext   = sampleAReg;
        sampleBNext   = sampleBReg;
        holdNext      = holdReg;
        parErrNext    = parErrReg;
        prescaleNext  = prescaleReg;
        parEnNext     = parEnReg;
        parTypeNext   = parTypeReg;
        pdataNext     = pdataReg;
        dataValidNext = dataValidReg;
`ifdef UART_RX_ERR_FLAGS_EN
        stpErrNext    = stpErrReg;
`endif

        if (stateReg != IDLE) begin
            if (atEarly) sampleANext = UartRx_RX_IN;
            if (atMid)   sampleBNext = UartRx_RX_IN;
            edgeCntNext = atEnd ? '0 : edgeCntReg + PRESCALE_WIDTH'(1);
        end

        case (stateReg)
            IDLE: begin
                if (!UartRx_RX_IN) begin
                    stateNext     = START;
                    edgeCntNext   = '0;
                    bitCntNext    = '0;
                    prescaleNext  = UartRx_prescale;
                    parEnNext     = UartRx_PAR_EN;
                    parTypeNext   = UartRx_Par_Type;
                    dataValidNext = 1'b0;
                    parErrNext    = 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
                    stpErrNext    = 1'b0;
`endif
                end
            end
            START: begin
                if (atDecide && voted) begin
                    stateNext   = IDLE;
                    edgeCntNext = '0;
                end else if (atEnd) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                if (atDecide) holdNext = {voted, holdReg[DATA_WIDTH-1:1]};
                if (atEnd) begin
                    if (bitCntReg == BIT_CNT_WIDTH'(DATA_WIDTH - 1)) begin
                        bitCntNext = '0;
                        stateNext  = parEnReg ? PARITY : STOP;
                    end else begin
                        bitCntNext = bitCntReg + BIT_CNT_WIDTH'(1);
                    end
                end
            end
            PARITY: begin
                if (atDecide) parErrNext = (voted != expectedPar);
                if (atEnd)    stateNext  = STOP;
            end
            STOP: begin
                // Leave early so a start bit right after the stop bit is caught.
                if (atDecide) begin
                    stateNext   = IDLE;
                    edgeCntNext = '0;
                    if (voted && !parErrReg) begin
                        pdataNext     = holdReg;
                        dataValidNext = 1'b1;
                    end else begin
                        dataValidNext = 1'b0;
                    end
`ifdef UART_RX_ERR_FLAGS_EN
                    stpErrNext = !voted;
`endif
                end
            end
            default: begin
                stateNext   = IDLE;
                edgeCntNext = '0;
            end
        endcase
    end

    assign UartRx_PDATA      = pdataReg;
    assign UartRx_Data_Valid = dataValidReg;
`ifdef UART_RX_ERR_FLAGS_EN
    assign UartRx_Par_Err    = parErrReg;
    assign UartRx_Stp_Err    = stpErrReg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes, a monitor pops them on Data_Valid.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] prescale;
    logic       rxIn;
    logic       parEn;
    logic       parType;
    logic [7:0] pdata;
    logic       dataValid;
`ifdef UART_RX_ERR_FLAGS_EN
    logic       parErr;
    logic       stpErr;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] expQ[$];
    int stpRise = 0;
    int parRise = 0;

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
        .UartRx_CLK       (clk),
        .UartRx_RST       (rst),
        .UartRx_prescale  (prescale),
        .UartRx_RX_IN     (rxIn),
        .UartRx_PAR_EN    (parEn),
        .UartRx_Par_Type  (parType),
        .UartRx_PDATA     (pdata),
        .UartRx_Data_Valid(dataValid)
`ifdef UART_RX_ERR_FLAGS_EN
        ,
        .UartRx_Par_Err   (parErr),
        .UartRx_Stp_Err   (stpErr)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every rising Data_Valid must match the oldest expected byte.
    initial begin
        logic       prevValid;
        logic [7:0] expData;
        logic       prevStp;
        logic       prevPar;
        prevValid = 1'b0;
        prevStp   = 1'b0;
        prevPar   = 1'b0;
        forever begin
            @(negedge clk);
            if (dataValid === 1'b1 && !prevValid) begin
                if (expQ.size() == 0) begin
                    check("unexpected_valid", {24'd0, pdata}, 32'h0000_0100);
                end else begin
                    expData = expQ.pop_front();
                    check("pdata", {24'd0, pdata}, {24'd0, expData});
                end
            end
            prevValid = (dataValid === 1'b1);
`ifdef UART_RX_ERR_FLAGS_EN
            if (stpErr === 1'b1 && !prevStp) stpRise++;
            if (parErr === 1'b1 && !prevPar) parRise++;
            prevStp = (stpErr === 1'b1);
            prevPar = (parErr === 1'b1);
`endif
        end
    end

    task automatic sendBit(input int pre, input logic b);
        rxIn = b;
        repeat (pre + 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rxIn = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic runFrame(input int pre, input bit pe, input bit pt, input logic [7:0] d,
                            input bit pb, input bit sb, input bit ok, input bit expPar, input bit expStp);
        int stp0;
        int par0;
        stp0     = stpRise;
        par0     = parRise;
        prescale = 5'(pre);
        parEn    = pe;
        parType  = pt;
        if (ok) expQ.push_back(d);
        sendBit(pre, 1'b0);
        for (int i = 0; i < 8; i++) sendBit(pre, d[i]);
        if (pe) sendBit(pre, pb);
        sendBit(pre, sb);
        rxIn = 1'b1;
        if (ok) begin
            check("valid_latency", expQ.size(), 0);
        end else begin
            idle(4 * (pre + 1));
            check("reject_valid", {31'd0, dataValid}, 0);
        end
`ifdef UART_RX_ERR_FLAGS_EN
        check("stp_err_flag", {31'd0, (stpRise != stp0)}, {31'd0, expStp});
        check("par_err_flag", {31'd0, (parRise != par0)}, {31'd0, expPar});
`else
        if (expPar || expStp) checks += 0;
`endif
        $display("frame pre=%0d pe=%0d pt=%0d data=%h par=%0d stop=%0d -> PDATA=%h valid=%0d",
                 pre, pe, pt, d, pb, sb, pdata, dataValid);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rxIn     = 1'b1;
        prescale = 5'd7;
        parEn    = 1'b0;
        parType  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pdata", {24'd0, pdata}, 0);
        check("reset_valid", {31'd0, dataValid}, 0);
        rst = 1'b0;
        idle(4);

        // pre, pe, pt, data, parity bit, stop bit, accepted, par err, stop err
        runFrame(7,  1, 0, 8'h55, 0, 1, 1, 0, 0);
        runFrame(7,  1, 1, 8'h55, 1, 1, 1, 0, 0);
        runFrame(7,  0, 0, 8'h55, 0, 1, 1, 0, 0);
        runFrame(7,  1, 0, 8'hA3, 0, 1, 1, 0, 0);
        runFrame(7,  1, 1, 8'h01, 0, 1, 1, 0, 0);
        runFrame(7,  0, 0, 8'h80, 0, 1, 1, 0, 0);
        runFrame(15, 1, 0, 8'h55, 0, 1, 1, 0, 0);
        runFrame(15, 1, 1, 8'h55, 1, 1, 1, 0, 0);
        runFrame(15, 0, 0, 8'h55, 0, 1, 1, 0, 0);
        runFrame(15, 1, 1, 8'hC7, 0, 1, 1, 0, 0);
        runFrame(31, 1, 0, 8'h55, 0, 1, 1, 0, 0);
        runFrame(31, 1, 1, 8'h55, 1, 1, 1, 0, 0);
        runFrame(31, 0, 0, 8'h55, 0, 1, 1, 0, 0);
        runFrame(31, 1, 0, 8'hE0, 1, 1, 1, 0, 0);
        runFrame(7,  1, 0, 8'h55, 0, 1, 1, 0, 0);

        // Rejected frames must leave PDATA at 0x55.
        runFrame(7,  1, 0, 8'h55, 0, 0, 0, 0, 1);
        check("stop_err_pdata", {24'd0, pdata}, 32'h55);
        runFrame(7,  1, 0, 8'h55, 1, 1, 0, 1, 0);
        check("par_err_pdata", {24'd0, pdata}, 32'h55);
        runFrame(7,  0, 0, 8'hAA, 0, 0, 0, 0, 1);
        check("stop_err2_pdata", {24'd0, pdata}, 32'h55);

        // Short low glitch while idle.
        prescale = 5'd7;
        rxIn = 1'b0;
        repeat (3) @(negedge clk);
        idle(40);
        check("glitch_valid", {31'd0, dataValid}, 0);
        check("glitch_pdata", {24'd0, pdata}, 32'h55);
        $display("glitch 3 clocks at pre=7 -> PDATA=%h valid=%0d", pdata, dataValid);

        // Reset asserted part-way through a frame.
        prescale = 5'd7;
        parEn    = 1'b1;
        parType  = 1'b0;
        sendBit(7, 1'b0);
        sendBit(7, 1'b1);
        sendBit(7, 1'b0);
        sendBit(7, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("midreset_pdata", {24'd0, pdata}, 0);
        check("midreset_valid", {31'd0, dataValid}, 0);
        rxIn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-frame reset -> PDATA=%h valid=%0d", pdata, dataValid);
        idle(4);
        runFrame(7,  1, 0, 8'h3C, 0, 1, 1, 0, 0);

        idle(8);
        check("scoreboard_drain", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Oversampling UART receiver. Recovers 8-bit frames from the serial line RX_IN: 1 start bit (0), 8 data bits LSB first, an optional even/odd parity bit, and 1 stop bit (1). The bit period is set at runtime by a prescale input. The block sits between the asynchronous serial pin (already synchronised upstream) and the parallel consumer, and presents received bytes on PDATA qualified by Data_Valid.

Parameters:
DATA_WIDTH, 8, data bits per frame.
PRESCALE_WIDTH, 5, width of the prescale input.

Ports:
UartRx_CLK  in  1  oversampling clock, rising edge.
UartRx_RST  in  1  asynchronous active-high reset.
UartRx_prescale  in  PRESCALE_WIDTH  clocks per bit minus 1; supported values 7, 15, 31 (8/16/32x oversampling).
UartRx_RX_IN  in  1  serial line, idle high.
UartRx_PAR_EN  in  1  1 = parity bit present in the frame.
UartRx_Par_Type  in  1  0 = even parity, 1 = odd parity.
UartRx_PDATA  out  DATA_WIDTH  last correctly received byte.
UartRx_Data_Valid  out  1  high while PDATA holds a newly accepted frame.

Behaviour:
- Reset (async, RST=1): FSM = IDLE, all counters 0, PDATA = 0x00, Data_Valid = 0.
- Config latch: prescale, PAR_EN and Par_Type are latched on start-bit detection and held for the whole frame.
- Bit period: P = prescale+1 clocks. An edge counter runs 0..prescale within each bit, then wraps to 0 and increments the bit counter.
- Sampling:
  - 3 samples at edge counts P/2-1, P/2 and P/2+1.
  - Bit value = majority of the 3 samples.
  - The bit is decided at count P/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: stay while RX_IN=1. RX_IN=0 moves to START with the edge counter cleared; that cycle counts as edge 0.
  - START: if the voted bit is 1 (glitch), return to IDLE with no outputs changed. Otherwise go to DATA at the end of the bit period.
  - DATA: shift voted bits into a holding register LSB first. After the 8th bit period, go to PARITY if PAR_EN, else STOP.
  - PARITY: compute the expected bit as XOR of data (even) or its inverse (odd). A mismatch sets an internal par_err. Then go to STOP.
  - STOP: at the decision sample (count P/2+1):
    - If stop=1 and no par_err: PDATA <= holding register and Data_Valid <= 1 on the next clock edge.
    - Otherwise: PDATA unchanged and Data_Valid <= 0.
    - Either way the FSM returns to IDLE immediately, so a start bit arriving right after the stop bit is accepted.
- Data_Valid:
  - Once set, it stays high until the next start bit is detected, then clears on that same clock edge.
  - Any rejected frame leaves it 0.
- Frame length: 10 bits without parity, 11 with parity. Accepted data is visible about 9.5 or 10.5 bit periods after the start edge.
- Rejected frames (stop error, parity error) never modify PDATA.
- A falling edge during any non-IDLE state is treated only as data, never as a resync.
- Prescale values other than 7/15/31 are unsupported; behaviour with them is unspecified.

Optional Feature:
Macro UART_RX_ERR_FLAGS_EN.
- Defined: adds outputs UartRx_Par_Err (1 bit) and UartRx_Stp_Err (1 bit).
  - Each is set on the decision clock of the failing bit.
  - Each holds until the next start bit is detected.
  - Both reset to 0.
  - Par_Err is only ever set when PAR_EN=1.
- Undefined: no extra ports. Error detection stays internal and only suppresses Data_Valid.

Test Plan:
- prescale=7, PAR_EN=1, Par_Type=0, frame start, data 0x55, parity 0, stop 1 -> PDATA=0x55, Data_Valid=1.
- prescale=7, Par_Type=1, data 0x55, parity 1 -> PDATA=0x55, Data_Valid=1. Repeat with PAR_EN=0 (10-bit frame) -> same result.
- prescale=7, PAR_EN=1 even, data 0x55, parity 0, stop 0 -> Data_Valid=0, PDATA stays 0x55 (Stp_Err=1 when the macro is on).
- prescale=7, even parity, data 0x55, parity bit 1 -> Data_Valid=0, PDATA unchanged (Par_Err=1 when the macro is on).
- prescale=15 and prescale=31: even, odd and no-parity frames of 0x55 -> PDATA=0x55, Data_Valid=1 each.
- RX_IN low pulse shorter than P/2 clocks while IDLE -> returns to IDLE, no output change. Assert RST mid-frame -> PDATA=0x00, Data_Valid=0, FSM=IDLE.
